// File: rtl/retire_buffer.sv
// Dual-retire reorder buffer: allocates in order, accepts two completions per cycle,
// and retires up to two done entries from the head into the architectural register file.
module retire_buffer #(
  parameter int unsigned AR_SIZE   = 6,
  parameter int unsigned ROB_DEPTH = 16,
  parameter int unsigned ROB_IDX   = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               alloc_valid,
  input  logic [AR_SIZE-1:0] alloc_rd,
  output logic               alloc_ready,
  output logic [ROB_IDX-1:0] alloc_idx,
  input  logic               cmpl_valid_a,
  input  logic [ROB_IDX-1:0] cmpl_idx_a,
  input  logic [31:0]        cmpl_data_a,
  input  logic               cmpl_valid_b,
  input  logic [ROB_IDX-1:0] cmpl_idx_b,
  input  logic [31:0]        cmpl_data_b,
  input  logic               flush,
  output logic               write_en,
  output logic [AR_SIZE-1:0] write_addr1,
  output logic [AR_SIZE-1:0] write_addr2,
  output logic [31:0]        write_data1,
  output logic [31:0]        write_data2,
  output logic [ROB_IDX:0]   rob_count
);

  localparam logic [ROB_IDX:0] DepthC = (ROB_IDX+1)'(ROB_DEPTH);

  // Entry storage
  logic [ROB_DEPTH-1:0] r_valid;
  logic [ROB_DEPTH-1:0] r_done;
  logic [AR_SIZE-1:0]   r_rd   [ROB_DEPTH];
  logic [31:0]          r_data [ROB_DEPTH];

  // Pointers and occupancy
  logic [ROB_IDX-1:0] r_head;
  logic [ROB_IDX-1:0] r_tail;
  logic [ROB_IDX:0]   r_count;

  // Registered retire port
  logic               r_write_en;
  logic [AR_SIZE-1:0] r_waddr1;
  logic [AR_SIZE-1:0] r_waddr2;
  logic [31:0]        r_wdata1;
  logic [31:0]        r_wdata2;

  // Next-state
  logic [ROB_DEPTH-1:0] w_valid_nxt;
  logic [ROB_DEPTH-1:0] w_done_nxt;
  logic [AR_SIZE-1:0]   w_rd_nxt   [ROB_DEPTH];
  logic [31:0]          w_data_nxt [ROB_DEPTH];
  logic [ROB_IDX-1:0]   w_head_nxt;
  logic [ROB_IDX-1:0]   w_tail_nxt;
  logic [ROB_IDX:0]     w_count_nxt;
  logic                 w_wen_nxt;
  logic [AR_SIZE-1:0]   w_waddr1_nxt;
  logic [AR_SIZE-1:0]   w_waddr2_nxt;
  logic [31:0]          w_wdata1_nxt;
  logic [31:0]          w_wdata2_nxt;

  logic               w_alloc_fire;
  logic               w_cmpl_a;
  logic               w_cmpl_b;
  logic               w_ret1;
  logic               w_ret2;
  logic [ROB_IDX-1:0] w_head_p1;

  assign alloc_ready = (r_count < DepthC);
  assign alloc_idx   = r_tail;
  assign rob_count   = r_count;
  assign write_en    = r_write_en;
  assign write_addr1 = r_waddr1;
  assign write_addr2 = r_waddr2;
  assign write_data1 = r_wdata1;
  assign write_data2 = r_wdata2;

  // Flush overrides allocation, completion and retirement in its cycle.
  assign w_alloc_fire = alloc_valid & alloc_ready & ~flush;
  assign w_cmpl_a     = cmpl_valid_a & r_valid[cmpl_idx_a] & ~flush;
  assign w_cmpl_b     = cmpl_valid_b & r_valid[cmpl_idx_b] & ~flush;
  assign w_head_p1    = r_head + ROB_IDX'(1);
  assign w_ret1       = ~flush & r_valid[r_head] & r_done[r_head];
  assign w_ret2       = w_ret1 & r_valid[w_head_p1] & r_done[w_head_p1];

  always_comb begin
    w_valid_nxt = r_valid;
    w_done_nxt  = r_done;
    w_rd_nxt    = r_rd;
    w_data_nxt  = r_data;
    // Port b first so port a wins on a shared tag.
    if (w_cmpl_b) begin
      w_done_nxt[cmpl_idx_b] = 1'b1;
      w_data_nxt[cmpl_idx_b] = cmpl_data_b;
    end
    if (w_cmpl_a) begin
      w_done_nxt[cmpl_idx_a] = 1'b1;
      w_data_nxt[cmpl_idx_a] = cmpl_data_a;
    end
    if (w_ret1) begin
      w_valid_nxt[r_head] = 1'b0;
      w_done_nxt[r_head]  = 1'b0;
    end
    if (w_ret2) begin
      w_valid_nxt[w_head_p1] = 1'b0;
      w_done_nxt[w_head_p1]  = 1'b0;
    end
    if (w_alloc_fire) begin
      w_valid_nxt[r_tail] = 1'b1;
      w_done_nxt[r_tail]  = 1'b0;
      w_rd_nxt[r_tail]    = alloc_rd;
    end
    if (flush) begin
      w_valid_nxt = '0;
      w_done_nxt  = '0;
    end
  end

  always_comb begin
    w_head_nxt  = r_head + ROB_IDX'(w_ret1) + ROB_IDX'(w_ret2);
    w_tail_nxt  = r_tail + ROB_IDX'(w_alloc_fire);
    w_count_nxt = r_count + (ROB_IDX+1)'(w_alloc_fire)
                - (ROB_IDX+1)'(w_ret1) - (ROB_IDX+1)'(w_ret2);
    if (flush) begin
      w_head_nxt  = '0;
      w_tail_nxt  = '0;
      w_count_nxt = '0;
    end
  end

  always_comb begin
    w_wen_nxt    = w_ret1;
    w_waddr1_nxt = w_ret1 ? r_rd[r_head]      : '0;
    w_wdata1_nxt = w_ret1 ? r_data[r_head]    : '0;
    w_waddr2_nxt = w_ret2 ? r_rd[w_head_p1]   : '0;
    w_wdata2_nxt = w_ret2 ? r_data[w_head_p1] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_valid    <= '0;
      r_done     <= '0;
      r_rd       <= '{default: '0};
      r_data     <= '{default: '0};
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_write_en <= 1'b0;
      r_waddr1   <= '0;
      r_waddr2   <= '0;
      r_wdata1   <= '0;
      r_wdata2   <= '0;
    end else begin
      r_valid    <= w_valid_nxt;
      r_done     <= w_done_nxt;
      r_rd       <= w_rd_nxt;
      r_data     <= w_data_nxt;
      r_head     <= w_head_nxt;
      r_tail     <= w_tail_nxt;
      r_count    <= w_count_nxt;
      r_write_en <= w_wen_nxt;
      r_waddr1   <= w_waddr1_nxt;
      r_waddr2   <= w_waddr2_nxt;
      r_wdata1   <= w_wdata1_nxt;
      r_wdata2   <= w_wdata2_nxt;
    end
  end

endmodule

// File: tb/tb_retire_buffer.sv
// Scoreboard bench for retire_buffer: directed stimulus queues expected ARF writes,
// a negedge monitor pops and compares every write_en pulse.
module tb_retire_buffer;

  localparam int AR  = 6;
  localparam int IDX = 4;

  logic           clk = 1'b0;
  logic           rstn;
  logic           alloc_valid;
  logic [AR-1:0]  alloc_rd;
  logic           alloc_ready;
  logic [IDX-1:0] alloc_idx;
  logic           cmpl_valid_a, cmpl_valid_b;
  logic [IDX-1:0] cmpl_idx_a, cmpl_idx_b;
  logic [31:0]    cmpl_data_a, cmpl_data_b;
  logic           flush;
  logic           write_en;
  logic [AR-1:0]  write_addr1, write_addr2;
  logic [31:0]    write_data1, write_data2;
  logic [IDX:0]   rob_count;

  always #5 clk = ~clk;

  retire_buffer #(.AR_SIZE(6), .ROB_DEPTH(16), .ROB_IDX(4)) dut (
    .clk(clk), .rstn(rstn),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .cmpl_valid_a(cmpl_valid_a), .cmpl_idx_a(cmpl_idx_a), .cmpl_data_a(cmpl_data_a),
    .cmpl_valid_b(cmpl_valid_b), .cmpl_idx_b(cmpl_idx_b), .cmpl_data_b(cmpl_data_b),
    .flush(flush), .write_en(write_en),
    .write_addr1(write_addr1), .write_addr2(write_addr2),
    .write_data1(write_data1), .write_data2(write_data2),
    .rob_count(rob_count)
  );

  typedef struct packed {
    logic [AR-1:0] a1;
    logic [31:0]   d1;
    logic [AR-1:0] a2;
    logic [31:0]   d2;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_tests = 0;
  int  n_fail  = 0;
  bit  mon_on  = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      if (write_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got addr1=%0d data1=0x%0h addr2=%0d, expected no write",
                   write_addr1, write_data1, write_addr2);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr1", 32'(write_addr1), 32'(mon_e.a1));
          check("wr_data1", write_data1, mon_e.d1);
          check("wr_addr2", 32'(write_addr2), 32'(mon_e.a2));
          check("wr_data2", write_data2, mon_e.d2);
        end
      end else begin
        check("write_en_known", 32'(write_en), 32'd0);
        check("idle_zero", write_data1 | write_data2 | 32'(write_addr1) | 32'(write_addr2), 32'd0);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [AR-1:0] rd);
    alloc_valid = 1'b1;
    alloc_rd    = rd;
    cyc(1);
    alloc_valid = 1'b0;
  endtask

  task automatic cmpl(input bit va, input logic [IDX-1:0] ia, input logic [31:0] da,
                      input bit vb, input logic [IDX-1:0] ib, input logic [31:0] db);
    cmpl_valid_a = va; cmpl_idx_a = ia; cmpl_data_a = da;
    cmpl_valid_b = vb; cmpl_idx_b = ib; cmpl_data_b = db;
    cyc(1);
    cmpl_valid_a = 1'b0;
    cmpl_valid_b = 1'b0;
  endtask

  task automatic expect_wr(input logic [AR-1:0] a1, input logic [31:0] d1,
                           input logic [AR-1:0] a2, input logic [31:0] d2);
    exp_q.push_back({a1, d1, a2, d2});
  endtask

  // rd allocated to each tag during the full/wrap phase (tag 5 got rd 1)
  function automatic logic [AR-1:0] rd_of(input int tag);
    return AR'(((tag - 5) & 15) + 1);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; flush = 1'b0; alloc_valid = 1'b0; alloc_rd = '0;
    cmpl_valid_a = 1'b0; cmpl_idx_a = '0; cmpl_data_a = '0;
    cmpl_valid_b = 1'b0; cmpl_idx_b = '0; cmpl_data_b = '0;
    cyc(2);
    rstn = 1'b1;
    check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    check("rst_alloc_idx", 32'(alloc_idx), 32'd0);
    check("rst_rob_count", 32'(rob_count), 32'd0);
    check("rst_write_en", 32'(write_en), 32'd0);
    mon_on = 1'b1;

    // Single retire latency
    do_alloc(6'd5);
    expect_wr(6'd5, 32'hDEADBEEF, 6'd0, 32'd0);
    cmpl(1, 4'd0, 32'hDEADBEEF, 0, 4'd0, 32'd0);
    check("lat_n1_no_write", 32'(write_en), 32'd0);
    cyc(1);
    check("lat_n2_write_en", 32'(write_en), 32'd1);
    check("lat_n2_addr1", 32'(write_addr1), 32'd5);
    check("lat_n2_addr2", 32'(write_addr2), 32'd0);
    check("lat_n2_count", 32'(rob_count), 32'd0);

    // Out-of-order completion, then dual retire
    do_alloc(6'd3);
    do_alloc(6'd7);
    cmpl(0, 4'd0, 32'd0, 1, 4'd2, 32'h77);
    cyc(3);
    check("ooo_pending_count", 32'(rob_count), 32'd2);
    expect_wr(6'd3, 32'h33, 6'd7, 32'h77);
    cmpl(1, 4'd1, 32'h33, 0, 4'd0, 32'd0);
    cyc(1);
    check("dual_addr1", 32'(write_addr1), 32'd3);
    check("dual_addr2", 32'(write_addr2), 32'd7);

    // Same tag on both ports: port a data kept
    do_alloc(6'd9);
    expect_wr(6'd9, 32'hAAAA0001, 6'd0, 32'd0);
    cmpl(1, 4'd3, 32'hAAAA0001, 1, 4'd3, 32'hBBBB0002);
    cyc(2);

    // rd=0 still retires, as address 0
    do_alloc(6'd0);
    expect_wr(6'd0, 32'h1234, 6'd0, 32'd0);
    cmpl(1, 4'd4, 32'h1234, 0, 4'd0, 32'd0);
    cyc(2);
    check("tail_after_five", 32'(alloc_idx), 32'd5);

    // Fill to 16, wrapping the tail 15 -> 0
    for (int i = 0; i < 16; i++) begin
      check("fill_alloc_idx", 32'(alloc_idx), 32'((5 + i) & 15));
      do_alloc(AR'(i + 1));
    end
    check("full_ready", 32'(alloc_ready), 32'd0);
    check("full_count", 32'(rob_count), 32'd16);
    alloc_valid = 1'b1; alloc_rd = 6'd63;
    cyc(1);
    alloc_valid = 1'b0;
    check("full_reject_count", 32'(rob_count), 32'd16);
    check("full_reject_idx", 32'(alloc_idx), 32'd5);
    expect_wr(rd_of(5), 32'h1005, 6'd0, 32'd0);
    cmpl(1, 4'd5, 32'h1005, 0, 4'd0, 32'd0);
    check("full_retire_cycle_ready", 32'(alloc_ready), 32'd0);
    cyc(1);
    check("after_retire_ready", 32'(alloc_ready), 32'd1);
    check("after_retire_count", 32'(rob_count), 32'd15);

    // Drain with pairs; pair (15,0) retires across the wrap
    expect_wr(rd_of(6), 32'h1006, 6'd0, 32'd0);
    cmpl(1, 4'd6, 32'h1006, 0, 4'd0, 32'd0);
    for (int k = 0; k < 7; k++) begin
      int a, b;
      a = (7 + 2 * k) & 15;
      b = (a + 1) & 15;
      expect_wr(rd_of(a), 32'h1000 + 32'(a), rd_of(b), 32'h1000 + 32'(b));
      cmpl(1, IDX'(a), 32'h1000 + 32'(a), 1, IDX'(b), 32'h1000 + 32'(b));
    end
    cyc(3);
    check("wrap_drained_count", 32'(rob_count), 32'd0);
    check("wrap_tail", 32'(alloc_idx), 32'd5);

    // Flush overrides a pending retire and a same-cycle completion
    for (int i = 0; i < 4; i++) do_alloc(AR'(20 + i));
    cmpl(1, 4'd5, 32'h5555, 0, 4'd0, 32'd0);
    flush = 1'b1; cmpl_valid_a = 1'b1; cmpl_idx_a = 4'd6; cmpl_data_a = 32'h6666;
    cyc(1);
    flush = 1'b0; cmpl_valid_a = 1'b0;
    check("flush_count", 32'(rob_count), 32'd0);
    check("flush_tail", 32'(alloc_idx), 32'd0);
    check("flush_ready", 32'(alloc_ready), 32'd1);
    check("flush_write_en", 32'(write_en), 32'd0);
    cyc(1);
    check("flush_write_en_n2", 32'(write_en), 32'd0);
    cmpl(1, 4'd5, 32'h5555, 1, 4'd6, 32'h6666);
    cyc(3);
    check("stale_cmpl_count", 32'(rob_count), 32'd0);

    // Reset beats flush/alloc with completed entries pending
    for (int i = 0; i < 5; i++) do_alloc(AR'(i + 1));
    cmpl(1, 4'd0, 32'h0A, 1, 4'd1, 32'h0B);
    rstn = 1'b0; flush = 1'b1; alloc_valid = 1'b1; alloc_rd = 6'd9;
    cyc(1);
    rstn = 1'b1; flush = 1'b0; alloc_valid = 1'b0;
    check("rst2_write_en", 32'(write_en), 32'd0);
    check("rst2_addr1", 32'(write_addr1), 32'd0);
    check("rst2_addr2", 32'(write_addr2), 32'd0);
    check("rst2_data1", write_data1, 32'd0);
    check("rst2_data2", write_data2, 32'd0);
    check("rst2_count", 32'(rob_count), 32'd0);
    check("rst2_alloc_idx", 32'(alloc_idx), 32'd0);
    check("rst2_alloc_ready", 32'(alloc_ready), 32'd1);
    cyc(3);
    do_alloc(6'd10);
    expect_wr(6'd10, 32'hCAFE, 6'd0, 32'd0);
    cmpl(1, 4'd0, 32'hCAFE, 0, 4'd0, 32'd0);
    cyc(2);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc(1);
    check("drain_outstanding", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/retire_buffer.md
RETIRE_BUFFER -- requirements
Module: retire_buffer

Interface
REQ-001 SHALL have parameter AR_SIZE, default 6, meaning architectural register address width.
REQ-002 SHALL have parameter ROB_DEPTH, default 16, meaning number of reorder entries (power of two).
REQ-003 SHALL have parameter ROB_IDX, default 4, meaning entry tag width, log2(ROB_DEPTH).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rstn, input, 1, meaning reset: synchronous, active-low.
REQ-006 SHALL have port alloc_valid, input, 1, meaning dispatch requests a new entry.
REQ-007 SHALL have port alloc_rd, input, AR_SIZE, meaning destination register of the dispatched instruction.
REQ-008 SHALL have port alloc_ready, output, 1, meaning an entry is free; combinational from registered count.
REQ-009 SHALL have port alloc_idx, output, ROB_IDX, meaning tag assigned to the allocation (current tail).
REQ-010 SHALL have ports cmpl_valid_a / cmpl_valid_b, input, 1 each, meaning a completion on port a / b.
REQ-011 SHALL have ports cmpl_idx_a / cmpl_idx_b, input, ROB_IDX each, meaning tag of the completing entry.
REQ-012 SHALL have ports cmpl_data_a / cmpl_data_b, input, 32 each, meaning result value.
REQ-013 SHALL have port flush, input, 1, meaning discard all entries.
REQ-014 SHALL have port write_en, output, 1, meaning ARF write strobe covering both slots.
REQ-015 SHALL have ports write_addr1 / write_addr2, output, AR_SIZE each, meaning ARF destinations; 0 means no write.
REQ-016 SHALL have ports write_data1 / write_data2, output, 32 each, meaning retired values.
REQ-017 SHALL have port rob_count, output, ROB_IDX+1, meaning occupied entries.

Function
REQ-018 SHALL store per entry: valid, done, rd, 32-bit data; circular buffer with head, tail and count registers.
REQ-019 SHALL accept an allocation when alloc_valid and alloc_ready are both high: write rd, set valid, clear done, tail+1 mod ROB_DEPTH.
REQ-020 SHALL drive alloc_ready = (rob_count < ROB_DEPTH); a retire in the same cycle does not raise alloc_ready when full.
REQ-021 SHALL, on cmpl_valid_x with a valid entry at cmpl_idx_x, store data and set done; completions to invalid entries are ignored.
REQ-022 SHALL, when both ports target the same tag in one cycle, keep port a's data.
REQ-023 SHALL evaluate retirement on registered valid/done bits: slot1 retires when head is valid and done; slot2 retires only if slot1 retires and head+1 mod ROB_DEPTH is valid and done.
REQ-024 SHALL register retire outputs: write_en high the cycle after the retire decision, iff at least one entry retired.
REQ-025 SHALL, on single retire, drive write_addr2=0 and write_data2=0; with no retire, drive write_en=0, all addresses and data 0.
REQ-026 SHALL pass rd=0 entries through as addr 0 (no architectural write), still consuming a retire slot.
REQ-027 SHALL clear valid of retired entries and advance head by the number retired (0, 1 or 2) mod ROB_DEPTH.
REQ-028 SHALL update count = count + alloc_fire - retired each cycle; simultaneous allocate and retire are both honored.
REQ-029 SHALL give latency: completion presented in cycle N -> done set at the end of N -> write_en high in cycle N+2.
REQ-030 SHALL, on flush, clear all valid/done, set head=tail=count=0, drive write_en=0 next cycle, and override allocate, complete and retire in that cycle.

Reset
REQ-031 SHALL, while rstn is low at a clock edge, clear all entries and set head=tail=count=0, write_en=0, write_addr1/2=0, write_data1/2=0.
REQ-032 SHALL take reset priority over flush and all other inputs, including mid-operation with entries pending.
REQ-033 SHALL drive alloc_ready=1, alloc_idx=0 and rob_count=0 after reset.

Verification
REQ-034 Allocate rd=5 (tag 0), complete tag 0 with data 0xDEADBEEF in cycle N -> cycle N+2: write_en=1, write_addr1=5, write_data1=0xDEADBEEF, write_addr2=0.
REQ-035 Allocate rd=3, rd=7; complete tag 1 before tag 0 -> no retire until tag 0 completes, then both retire in one cycle: addr1=3, addr2=7.
REQ-036 Allocate 16 entries -> alloc_ready=0, rob_count=16; 17th alloc_valid not accepted; after one retire alloc_ready=1.
REQ-037 Run more than 16 allocate/retire pairs -> tags wrap 15 to 0, and slot2 retires from index 0 when head=15.
REQ-038 Fill 4 entries, assert flush in the same cycle as a completion -> rob_count=0, write_en=0, later completion to the old tag ignored.
REQ-039 Drop rstn for one cycle with 5 entries pending -> all outputs 0, rob_count=0, alloc_idx=0 next cycle.
